// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared gate-op encoding, sweeper FSM states and reference gate function
//
// Purpose: common types for the logic-gate library and the truth-table sweeper.
//   op_e      : gate function encoding (codes 6..7 are illegal)
//   state_e   : sweeper FSM states
//   ref_gate  : n-input reduction of vec by op, usable from benches
package logic_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int unsigned MAX_N_IN = 8;
   localparam logic [2:0]  OP_LAST  = 3'd5;

   // Only the low n bits of vec take part; illegal op codes give 0.
   function automatic logic ref_gate(input logic [2:0] op,
                                     input logic [MAX_N_IN-1:0] vec,
                                     input int unsigned n);
      logic all_one;
      logic any_one;
      logic parity;
      logic res;
      all_one = 1'b1;
      any_one = 1'b0;
      parity  = 1'b0;
      for (int unsigned i = 0; i < MAX_N_IN; i++) begin
         if (i < n) begin
            all_one = all_one & vec[i];
            any_one = any_one | vec[i];
            parity  = parity ^ vec[i];
         end
      end
      case (op)
         OP_AND:  res = all_one;
         OP_OR:   res = any_one;
         OP_XOR:  res = parity;
         OP_NAND: res = ~all_one;
         OP_NOR:  res = ~any_one;
         OP_XNOR: res = ~parity;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/nary_gate.sv
// rtl/nary_gate.sv - parametrised N_IN-input combinational gate selected by op
//
// Purpose: reference gate for the sweeper; also usable as a gate under test.
// Ports:
//   op   in  3     gate function (op_e encoding; 6..7 drive y=0)
//   vec  in  N_IN  gate inputs
//   y    out 1     gate output
module nary_gate
   import logic_pkg::*;
#(
   parameter int N_IN = 2
) (
   input  logic [2:0]      op,
   input  logic [N_IN-1:0] vec,
   output logic            y
);

   // With N_IN=1 the reductions collapse to buffer / inverter naturally.
   always_comb begin
      y = 1'b0;
      case (op)
         OP_AND:  y = &vec;
         OP_OR:   y = |vec;
         OP_XOR:  y = ^vec;
         OP_NAND: y = ~(&vec);
         OP_NOR:  y = ~(|vec);
         OP_XNOR: y = ~(^vec);
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_truth_sweeper.sv
// rtl/gate_truth_sweeper.sv - walks all input vectors of an external gate and checks its truth table
//
// Purpose: drives every N_IN-bit vector to a gate under test, holds it SETTLE
// cycles, samples the response into table_out and counts disagreements with
// an internal reference gate of the latched function.
// Ports:
//   clk        in  1       clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   start      in  1       sweep request, honoured only in IDLE with op<=5
//   op         in  3       gate function, latched on accepted start
//   dut_in     out N_IN    vector driven to the gate under test
//   dut_out    in  1       gate-under-test response
//   sample     out 1       high in the SAMPLE cycle of each vector
//   busy       out 1       high in APPLY/SAMPLE/DONE
//   done       out 1       one-cycle end-of-sweep pulse
//   table_out  out 2^N_IN  captured truth table, bit i = response to vector i
//   err_cnt    out N_IN+1  vectors whose response differed from reference
//   pass       out 1       err_cnt==0 for the last completed sweep
module gate_truth_sweeper
   import logic_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2:0]             op,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   sample,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic [N_IN:0]          err_cnt,
   output logic                   pass
);

   localparam int              NVEC      = 1 << N_IN;
   localparam logic [N_IN-1:0] IDX_LAST  = '1;
   localparam logic [7:0]      SETTLE_M1 = 8'(SETTLE - 1);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [NVEC-1:0]   table_q, table_d;
   logic [N_IN:0]     err_q, err_d;
   logic              pass_q, pass_d;
   logic              ref_bit;

   nary_gate #(.N_IN(N_IN)) u_ref (
      .op  (op_q),
      .vec (idx_q),
      .y   (ref_bit)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      err_d   = err_q;
      pass_d  = pass_q;
      case (state_q)
         ST_IDLE: begin
            if (start && (op <= OP_LAST)) begin
               state_d = ST_APPLY;
               op_d    = op;
               idx_d   = '0;
               cnt_d   = '0;
               table_d = '0;
               err_d   = '0;
               pass_d  = 1'b0;
            end
         end
         ST_APPLY: begin
            if (cnt_q == SETTLE_M1) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_SAMPLE: begin
            table_d[idx_q] = dut_out;
            if (dut_out != ref_bit) begin
               err_d = err_q + (N_IN+1)'(1);
            end
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
               // pass must already be valid while done is high, so it is
               // taken from the final count on the way into DONE.
               pass_d  = (err_d == '0);
            end else begin
               state_d = ST_APPLY;
               idx_d   = idx_q + N_IN'(1);
               cnt_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
      end
   end

   // idx is not advanced past the last vector, so dut_in keeps it through DONE/IDLE.
   assign dut_in    = idx_q;
   assign sample    = (state_q == ST_SAMPLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign table_out = table_q;
   assign err_cnt   = err_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// tb/tb_gate_truth_sweeper.sv - randomized and directed checks of gate_truth_sweeper
module tb_gate_truth_sweeper;

   logic        clk;
   logic        rst_n;
   logic [2:0]  op;
   logic [2:0]  start_v;
   logic [2:0]  sample_v, busy_v, done_v, pass_v;
   logic [2:0]  gut_op;
   logic [2:0]  gut_mode;
   logic [255:0] gut_tbl [3];

   logic [1:0]  dut_in_a;
   logic [2:0]  dut_in_b;
   logic [0:0]  dut_in_c;
   logic        dut_out_a, dut_out_b, dut_out_c;
   logic        gut_y_a, gut_y_b, gut_y_c;
   logic [3:0]  table_a;
   logic [7:0]  table_b;
   logic [1:0]  table_c;
   logic [2:0]  err_a;
   logic [3:0]  err_b;
   logic [1:0]  err_c;

   logic [7:0]   v_in  [3];
   logic [255:0] v_tbl [3];
   logic [8:0]   v_err [3];

   int errors = 0;
   int checks = 0;

   gate_truth_sweeper #(.N_IN(2), .SETTLE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op),
      .dut_in(dut_in_a), .dut_out(dut_out_a), .sample(sample_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .table_out(table_a),
      .err_cnt(err_a), .pass(pass_v[0]));

   gate_truth_sweeper #(.N_IN(3), .SETTLE(3)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op),
      .dut_in(dut_in_b), .dut_out(dut_out_b), .sample(sample_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .table_out(table_b),
      .err_cnt(err_b), .pass(pass_v[1]));

   gate_truth_sweeper #(.N_IN(1), .SETTLE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op),
      .dut_in(dut_in_c), .dut_out(dut_out_c), .sample(sample_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .table_out(table_c),
      .err_cnt(err_c), .pass(pass_v[2]));

   nary_gate #(.N_IN(2)) u_gut_a (.op(gut_op), .vec(dut_in_a), .y(gut_y_a));
   nary_gate #(.N_IN(3)) u_gut_b (.op(gut_op), .vec(dut_in_b), .y(gut_y_b));
   nary_gate #(.N_IN(1)) u_gut_c (.op(gut_op), .vec(dut_in_c), .y(gut_y_c));

   assign dut_out_a = gut_mode[0] ? gut_tbl[0][dut_in_a] : gut_y_a;
   assign dut_out_b = gut_mode[1] ? gut_tbl[1][dut_in_b] : gut_y_b;
   assign dut_out_c = gut_mode[2] ? gut_tbl[2][dut_in_c] : gut_y_c;

   assign v_in[0]  = 8'(dut_in_a);
   assign v_in[1]  = 8'(dut_in_b);
   assign v_in[2]  = 8'(dut_in_c);
   assign v_tbl[0] = 256'(table_a);
   assign v_tbl[1] = 256'(table_b);
   assign v_tbl[2] = 256'(table_c);
   assign v_err[0] = 9'(err_a);
   assign v_err[1] = 9'(err_b);
   assign v_err[2] = 9'(err_c);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int n_of(input int k);
      return (k == 0) ? 2 : (k == 1) ? 3 : 1;
   endfunction

   function automatic int s_of(input int k);
      return (k == 1) ? 3 : 1;
   endfunction

   // Gate function from counting ones among the n inputs.
   function automatic bit model_ref(input int opv, input int vec, input int n);
      int ones;
      ones = $countones(vec & ((1 << n) - 1));
      case (opv)
         0: return ones == n;
         1: return ones > 0;
         2: return (ones % 2) == 1;
         3: return ones != n;
         4: return ones == 0;
         5: return (ones % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   // Entered just after a falling edge; returns just after the falling edge of
   // the IDLE cycle that follows DONE.
   task automatic run_sweep(input int k, input int opv, input bit hold, input bit disturb);
      int n, s, nvec, total, exp_err, exp_v;
      bit g, exp_sample, exp_done;
      logic [255:0] exp_tbl;
      n = n_of(k);
      s = s_of(k);
      nvec = 1 << n;
      total = nvec * (s + 1);
      exp_tbl = '0;
      exp_err = 0;
      for (int i = 0; i < nvec; i++) begin
         g = gut_mode[k] ? gut_tbl[k][i] : model_ref(int'(gut_op), i, n);
         exp_tbl[i] = g;
         if (g != model_ref(opv, i, n)) exp_err++;
      end
      op = 3'(opv);
      start_v[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start_v[k] = 1'b0;
      checks++;
      if (v_tbl[k] !== '0 || v_err[k] !== '0 || pass_v[k] !== 1'b0) begin
         errors++;
         $display("FAIL clear_on_start k=%0d: table=%0h err=%0d pass=%b, want 0/0/0", k, v_tbl[k], v_err[k], pass_v[k]);
      end
      for (int cyc = 0; cyc <= total; cyc++) begin
         exp_sample = (cyc < total) && ((cyc % (s + 1)) == s);
         exp_done = (cyc == total);
         exp_v = (cyc / (s + 1) < nvec) ? cyc / (s + 1) : nvec - 1;
         checks++;
         if (busy_v[k] !== 1'b1 || sample_v[k] !== exp_sample || done_v[k] !== exp_done) begin
            errors++;
            $display("FAIL timing k=%0d cyc=%0d: busy=%b sample=%b done=%b, want 1/%b/%b", k, cyc, busy_v[k], sample_v[k], done_v[k], exp_sample, exp_done);
         end
         checks++;
         if (v_in[k] !== 8'(exp_v)) begin
            errors++;
            $display("FAIL dut_in k=%0d cyc=%0d: got %0d want %0d", k, cyc, v_in[k], exp_v);
         end
         if (disturb && cyc == 3) begin
            start_v[k] = 1'b1;
            op = 3'($urandom_range(0, 7));
         end
         if (disturb && cyc == 6) begin
            start_v[k] = 1'b0;
            op = 3'd7;
         end
         if (cyc == total) begin
            checks++;
            if (v_tbl[k] !== exp_tbl || v_err[k] !== 9'(exp_err) || pass_v[k] !== (exp_err == 0)) begin
               errors++;
               $display("FAIL result k=%0d op=%0d: table=%0h err=%0d pass=%b, want %0h/%0d/%b", k, opv, v_tbl[k], v_err[k], pass_v[k], exp_tbl, exp_err, exp_err == 0);
            end
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      checks++;
      if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || sample_v[k] !== 1'b0 || pass_v[k] !== (exp_err == 0) || v_tbl[k] !== exp_tbl || v_in[k] !== 8'(nvec - 1)) begin
         errors++;
         $display("FAIL after_done k=%0d: busy=%b done=%b sample=%b pass=%b table=%0h in=%0d", k, busy_v[k], done_v[k], sample_v[k], pass_v[k], v_tbl[k], v_in[k]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start_v = '0;
      op = 3'd0;
      gut_op = 3'd0;
      gut_mode = '0;
      for (int k = 0; k < 3; k++) gut_tbl[k] = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (v_in[k] !== '0 || sample_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || v_tbl[k] !== '0 || v_err[k] !== '0 || pass_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset k=%0d: in=%0d sample=%b busy=%b done=%b table=%0h err=%0d pass=%b, want all 0", k, v_in[k], sample_v[k], busy_v[k], done_v[k], v_tbl[k], v_err[k], pass_v[k]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_and;
      gut_mode[0] = 1'b0;
      gut_op = 3'd0;
      run_sweep(0, 0, 1'b0, 1'b0);
      checks++;
      if (v_tbl[0] !== 256'h8) begin
         errors++;
         $display("FAIL and_table: got %0h want 8", v_tbl[0]);
      end
   endtask

   task automatic test_xor_tied0;
      gut_mode[0] = 1'b1;
      gut_tbl[0] = '0;
      run_sweep(0, 2, 1'b0, 1'b0);
      checks++;
      if (v_err[0] !== 9'd2 || pass_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL xor_tied0: err=%0d pass=%b want 2/0", v_err[0], pass_v[0]);
      end
   endtask

   task automatic test_nand3;
      gut_mode[1] = 1'b0;
      gut_op = 3'd3;
      run_sweep(1, 3, 1'b0, 1'b0);
      checks++;
      if (v_tbl[1] !== 256'h7f || v_err[1] !== 9'd0) begin
         errors++;
         $display("FAIL nand3: table=%0h err=%0d want 7f/0", v_tbl[1], v_err[1]);
      end
   endtask

   task automatic test_illegal_op;
      for (int code = 6; code <= 7; code++) begin
         op = 3'(code);
         start_v[0] = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (busy_v[0] !== 1'b0 || sample_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
               errors++;
               $display("FAIL illegal_op op=%0d c=%0d: busy=%b sample=%b done=%b want 0", code, c, busy_v[0], sample_v[0], done_v[0]);
            end
         end
         start_v[0] = 1'b0;
      end
   endtask

   task automatic test_disturb;
      gut_mode[0] = 1'b0;
      gut_op = 3'd1;
      run_sweep(0, 1, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid;
      gut_mode[0] = 1'b0;
      gut_op = 3'd0;
      op = 3'd0;
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (v_in[0] !== 8'd2 || busy_v[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_vector2: in=%0d busy=%b want 2/1", v_in[0], busy_v[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (v_in[0] !== '0 || sample_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || v_tbl[0] !== '0 || v_err[0] !== '0 || pass_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: in=%0d sample=%b busy=%b done=%b table=%0h err=%0d pass=%b want all 0", v_in[0], sample_v[0], busy_v[0], done_v[0], v_tbl[0], v_err[0], pass_v[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      gut_mode[2] = 1'b0;
      gut_op = 3'd4;
      run_sweep(2, 4, 1'b1, 1'b0);
      checks++;
      if (v_tbl[2] !== 256'h1 || pass_v[2] !== 1'b1) begin
         errors++;
         $display("FAIL nor1_table: table=%0h pass=%b want 1/1", v_tbl[2], pass_v[2]);
      end
      gut_mode[2] = 1'b1;
      gut_tbl[2] = '0;
      run_sweep(2, 4, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      int k, opv;
      for (int it = 0; it < 10; it++) begin
         k = $urandom_range(0, 2);
         opv = $urandom_range(0, 5);
         gut_mode[k] = 1'b1;
         for (int w = 0; w < 8; w++) gut_tbl[k][w*32 +: 32] = $urandom;
         if (($urandom_range(0, 3)) == 0) begin
            for (int i = 0; i < (1 << n_of(k)); i++) gut_tbl[k][i] = model_ref(opv, i, n_of(k));
         end
         run_sweep(k, opv, 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_xor_tied0();
      test_nand3();
      test_illegal_op();
      test_disturb();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gate_truth_sweeper.md
# gate_truth_sweeper

- Self-checking truth-table sweeper for an external combinational gate under test (GUT), in hardware.
- Walks all 2^N_IN input vectors and holds each for a programmable settle time. It then samples the GUT output into a truth-table register and compares it against an internal N-input reference gate of the selected function.
- Reports the mismatch count and a pass flag.
- Sits beside the logic-gate library as the parametrised, clocked successor of the per-gate directed benches; it is used for on-chip gate checks and as a reusable stimulus/checker.

## Interface
Parameters:
- N_IN, 2, number of gate inputs; legal 1..8.
- SETTLE, 1, cycles each vector is held before sampling; legal 1..255.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- op  in  3  gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6–7 illegal.
- dut_in  out  N_IN  vector driven to the GUT.
- dut_out  in  1  GUT response.
- sample  out  1  high during the SAMPLE cycle of each vector.
- busy  out  1  high from the first edge after an accepted start until DONE is left.
- done  out  1  one-cycle pulse at end of sweep.
- table_out  out  2^N_IN  captured truth table; bit i = GUT response to vector i.
- err_cnt  out  N_IN+1  number of vectors where dut_out ≠ reference.
- pass  out  1  err_cnt==0 for the last completed sweep; valid from done, held until next accepted start.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE: start=1 with op≤5 → latch op, clear idx, table_out, err_cnt, pass; go to APPLY.
  - start with op 6/7 is ignored: no state change, busy stays 0.
- APPLY: dut_in=idx; settle counter runs SETTLE cycles, then go to SAMPLE.
- SAMPLE: sample=1.
  - At the exiting edge: table_out[idx]←dut_out.
  - If dut_out ≠ ref(op, idx), then err_cnt+1.
  - If idx = 2^N_IN−1, go to DONE; else idx+1 and go to APPLY.
- DONE: done=1, pass←(err_cnt==0); next edge returns to IDLE.
- Reference model: N_IN-input reduction of idx by the latched op.
- N_IN=1: AND/OR/XOR reduce to buffer, NAND/NOR/XNOR to inverter.
- start while busy or in DONE: ignored; no restart, no queuing.
- op changes during a sweep: ignored; the latched op is used.
- err_cnt cannot overflow (max 2^N_IN fits in N_IN+1 bits).
- dut_in holds the last vector in DONE/IDLE until the next sweep drives 0.

## Timing
- Reset (async assert, sync-safe release) forces:
  - state IDLE;
  - dut_in=0, sample=0, busy=0, done=0, table_out=0, err_cnt=0, pass=0.
- Reset mid-sweep aborts immediately; partial results are discarded (cleared).
- Edge E0 accepts start: dut_in=0 and busy=1 are visible after E0.
- Per vector: SETTLE cycles in APPLY + 1 cycle in SAMPLE.
- dut_out is captured at the edge ending SAMPLE, i.e. after SETTLE+1 full cycles of stable dut_in.
- done is high for the single cycle following edge E0 + 2^N_IN·(SETTLE+1).
- busy falls with done's falling edge; a new start is accepted at the following edge.
- table_out/err_cnt update incrementally; they are final when done=1.

## Structure
- Shared package logic_pkg:
  - op encoding enum (OP_AND..OP_XNOR);
  - FSM state enum;
  - function ref_gate(op, vec) for reuse by benches.
- Sub-module nary_gate: parametrised N_IN-input combinational gate selected by op. It is the internal reference, and is also instantiable as a GUT in benches.
- Top: FSM, idx counter (N_IN bits), settle counter (8 bits), result registers.

## Test plan
- N_IN=2, SETTLE=1, op=AND, GUT=nary_gate AND → table_out=4'b1000, err_cnt=0, pass=1, done pulse 8 cycles after start edge.
- N_IN=2, op=XOR, GUT output tied 0 → table_out=4'b0000, err_cnt=2, pass=0.
- N_IN=3, SETTLE=3, op=NAND, matching GUT → table_out=8'b0111_1111, err_cnt=0, done at 32 cycles; dut_in stable 4 cycles per vector.
- start with op=6 → busy stays 0, no sample pulses. Start pulsed again mid-sweep and op toggled → sweep unaffected, single done.
- rst_n asserted during vector 2 of a sweep → all outputs 0 at once. New start after release → full clean sweep with correct results.
- N_IN=1, op=NOR, GUT=inverter → table_out=2'b01, pass=1. Back-to-back sweeps: start held high → second sweep begins the cycle after DONE and clears prior results.
